// File: rtl/mm_result_wb_buffer.sv
// Result write-back buffer: de-skews the diagonal MXU result wavefront into
// row-major lines and streams them to the output RAM at a byte-addressed start.
module mm_result_wb_buffer #(
    parameter int DIM = 16,
    parameter int EW  = 8,
    parameter int AW  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lsu_wb_ctrl_start,
    input  logic [3:0]            lsu_wb_ctrl_row_len,
    input  logic [3:0]            lsu_wb_ctrl_col_len,
    input  logic [11:0]           lsu_wb_ctrl_start_addr,
    input  logic [DIM-1:0]        mxu_wb_vld,
    input  logic [DIM*EW-1:0]     mxu_wb_data,
    output logic                  wb_ram_write_vld,
    input  logic                  wb_ram_write_rdy,
    output logic [AW-1:0]         wb_ram_write_addr,
    output logic [DIM*EW-1:0]     wb_ram_write_data,
    output logic [DIM-1:0]        wb_ram_write_strb,
    output logic                  wb_busy,
    output logic                  wb_done,
    output logic                  wb_err
);

    localparam int LW = $clog2(DIM);
    localparam int CW = LW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE
    } state_t;

    state_t                         state_q, state_d;
    logic [LW-1:0]                  row_len_q, row_len_d;
    logic [LW-1:0]                  col_len_q, col_len_d;
    logic [AW+LW-1:0]               addr_q, addr_d;
    logic [CW-1:0]                  cyc_q, cyc_d;
    logic [LW-1:0]                  row_q, row_d;
    logic [DIM-1:0][DIM-1:0][EW-1:0] entry_q, entry_d;
    logic                           err_q, err_d;
    logic                           done_q, done_d;

    logic [CW-1:0]                  need;
    logic [DIM-1:0]                 exp_vld;
    logic [DIM-1:0][LW-1:0]         ent_row;
    logic [LW-1:0]                  offset;
    logic [AW-1:0]                  line_base;
    logic [31:0]                    mask32;
    logic                           overflow;
    logic [DIM-1:0][EW-1:0]         rot;

    assign need      = {1'b0, row_len_q} + {1'b0, col_len_q};
    assign offset    = addr_q[LW-1:0];
    assign line_base = addr_q[AW+LW-1:LW];

    // Column j sees row r of the tile at collect cycle r + j.
    always_comb begin
        exp_vld = '0;
        ent_row = '0;
        for (int j = 0; j < DIM; j++) begin
            exp_vld[j] = (CW'(j) <= {1'b0, col_len_q}) && (cyc_q >= CW'(j)) &&
                         (cyc_q <= CW'(j) + {1'b0, row_len_q});
            ent_row[j] = LW'(cyc_q - CW'(j));
        end
    end

    // Bytes pushed past the top of the line by the offset show up in mask32[31:DIM].
    assign mask32   = ((32'd1 << (32'(col_len_q) + 32'd1)) - 32'd1) << offset;
    assign overflow = |mask32[31:DIM];

    always_comb begin
        rot = '0;
        for (int k = 0; k < DIM; k++) begin
            rot[k] = entry_q[row_q][LW'(k) - offset];
        end
    end

    always_comb begin
        state_d   = state_q;
        row_len_d = row_len_q;
        col_len_d = col_len_q;
        addr_d    = addr_q;
        cyc_d     = cyc_q;
        row_d     = row_q;
        entry_d   = entry_q;
        err_d     = err_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lsu_wb_ctrl_start) begin
                    row_len_d = lsu_wb_ctrl_row_len;
                    col_len_d = lsu_wb_ctrl_col_len;
                    addr_d    = lsu_wb_ctrl_start_addr;
                    cyc_d     = '0;
                    err_d     = 1'b0;
                    state_d   = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // Capture is driven by the expected pattern, not the incoming valids.
                for (int j = 0; j < DIM; j++) begin
                    if (exp_vld[j]) begin
                        entry_d[ent_row[j]][j] = mxu_wb_data[j*EW +: EW];
                    end
                end
                if (mxu_wb_vld != exp_vld) begin
                    err_d = 1'b1;
                end
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == need) begin
                    row_d   = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (overflow) begin
                    err_d = 1'b1;
                end
                if (wb_ram_write_rdy) begin
                    row_d = row_q + 1'b1;
                    if (row_q == row_len_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_len_q <= '0;
            col_len_q <= '0;
            addr_q    <= '0;
            cyc_q     <= '0;
            row_q     <= '0;
            entry_q   <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_len_q <= row_len_d;
            col_len_q <= col_len_d;
            addr_q    <= addr_d;
            cyc_q     <= cyc_d;
            row_q     <= row_d;
            entry_q   <= entry_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign wb_ram_write_vld  = (state_q == S_WRITE);
    assign wb_ram_write_addr = wb_ram_write_vld ? line_base + AW'(row_q) : '0;
    assign wb_ram_write_data = wb_ram_write_vld ? rot : '0;
    assign wb_ram_write_strb = wb_ram_write_vld ? mask32[DIM-1:0] : '0;
    assign wb_busy           = (state_q != S_IDLE);
    assign wb_done           = done_q;
    assign wb_err            = err_q;

endmodule

// File: tb/tb_mm_result_wb_buffer.sv
// Self-checking bench for mm_result_wb_buffer: directed tiles plus random tiles,
// checked against a tile-level model of the de-skewed RAM lines.
module tb_mm_result_wb_buffer;

    logic         clk;
    logic         rst;
    logic         lsu_wb_ctrl_start;
    logic [3:0]   lsu_wb_ctrl_row_len;
    logic [3:0]   lsu_wb_ctrl_col_len;
    logic [11:0]  lsu_wb_ctrl_start_addr;
    logic [15:0]  mxu_wb_vld;
    logic [127:0] mxu_wb_data;
    logic         wb_ram_write_vld;
    logic         wb_ram_write_rdy;
    logic [7:0]   wb_ram_write_addr;
    logic [127:0] wb_ram_write_data;
    logic [15:0]  wb_ram_write_strb;
    logic         wb_busy;
    logic         wb_done;
    logic         wb_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Tile results and the buffer contents the block should hold (persist across tiles).
    logic [7:0] res [16][16];
    logic [7:0] ent [16][16];

    mm_result_wb_buffer dut (
        .clk                    (clk),
        .rst                    (rst),
        .lsu_wb_ctrl_start      (lsu_wb_ctrl_start),
        .lsu_wb_ctrl_row_len    (lsu_wb_ctrl_row_len),
        .lsu_wb_ctrl_col_len    (lsu_wb_ctrl_col_len),
        .lsu_wb_ctrl_start_addr (lsu_wb_ctrl_start_addr),
        .mxu_wb_vld             (mxu_wb_vld),
        .mxu_wb_data            (mxu_wb_data),
        .wb_ram_write_vld       (wb_ram_write_vld),
        .wb_ram_write_rdy       (wb_ram_write_rdy),
        .wb_ram_write_addr      (wb_ram_write_addr),
        .wb_ram_write_data      (wb_ram_write_data),
        .wb_ram_write_strb      (wb_ram_write_strb),
        .wb_busy                (wb_busy),
        .wb_done                (wb_done),
        .wb_err                 (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < 16; r++)
            for (int j = 0; j < 16; j++)
                ent[r][j] = 8'h00;
    endtask

    // stall < 0 picks a random 0..2 wait per line; mis_c/stray_c < 0 disable those events.
    task automatic run_tile(input int rl, input int cl, input logic [11:0] sa, input int stall,
                            input int mis_c, input int stray_c, input bit abort, input bit pat);
        int           need;
        int           off;
        int           nst;
        bit           err_exp;
        logic [15:0]  v;
        logic [127:0] d;
        logic [127:0] ed;
        logic [15:0]  es;
        need = rl + cl;
        off  = int'(sa[3:0]);
        for (int r = 0; r < 16; r++)
            for (int j = 0; j < 16; j++)
                res[r][j] = pat ? 8'(r * 16 + j) : 8'($urandom);

        @(negedge clk);
        lsu_wb_ctrl_start      = 1'b1;
        lsu_wb_ctrl_row_len    = 4'(rl);
        lsu_wb_ctrl_col_len    = 4'(cl);
        lsu_wb_ctrl_start_addr = sa;

        // Result (r, j) leaves the array on collect cycle r + j.
        for (int c = 0; c <= need; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("busy_in_collect", wb_busy, 1);
                chk("err_clear_on_start", wb_err, 0);
                chk("no_write_in_collect", wb_ram_write_vld, 0);
            end
            lsu_wb_ctrl_start      = (c == stray_c);
            lsu_wb_ctrl_row_len    = 4'($urandom);
            lsu_wb_ctrl_col_len    = 4'($urandom);
            lsu_wb_ctrl_start_addr = 12'($urandom);
            v = '0;
            d = {$urandom, $urandom, $urandom, $urandom};
            for (int j = 0; j <= cl; j++) begin
                if (c - j >= 0 && c - j <= rl) begin
                    v[j] = 1'b1;
                    d[j*8 +: 8] = res[c-j][j];
                end
            end
            if (c == mis_c) v[3] = ~v[3];
            mxu_wb_vld  = v;
            mxu_wb_data = d;
        end

        @(negedge clk);
        lsu_wb_ctrl_start = 1'b0;
        mxu_wb_vld        = '0;
        mxu_wb_data       = '0;

        err_exp = (mis_c >= 0) || (cl + off > 15);
        for (int r = 0; r <= rl; r++)
            for (int j = 0; j <= cl; j++)
                ent[r][j] = res[r][j];
        es = '0;
        for (int j = 0; j <= cl; j++)
            if (j + off < 16) es[j + off] = 1'b1;

        for (int r = 0; r <= rl; r++) begin
            for (int k = 0; k < 16; k++)
                ed[k*8 +: 8] = ent[r][(k - off) & 15];
            nst = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            for (int s = 0; s <= nst; s++) begin
                if (!(r == 0 && s == 0)) @(negedge clk);
                chk("write_vld", wb_ram_write_vld, 1);
                chk("write_addr", wb_ram_write_addr, 8'(sa[11:4] + r));
                chk("write_data", wb_ram_write_data, ed);
                chk("write_strb", wb_ram_write_strb, es);
                chk("no_early_done", wb_done, 0);
                wb_ram_write_rdy = (s == nst);
            end
            if (abort) begin
                @(negedge clk);
                wb_ram_write_rdy = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_vld", wb_ram_write_vld, 0);
                chk("abort_busy", wb_busy, 0);
                chk("abort_done", wb_done, 0);
                chk("abort_addr", wb_ram_write_addr, 0);
                chk("abort_err", wb_err, 0);
                clear_model();
                @(negedge clk);
                chk("abort_no_done_later", wb_done, 0);
                return;
            end
        end

        @(negedge clk);
        wb_ram_write_rdy = 1'b0;
        chk("done_pulse", wb_done, 1);
        chk("idle_vld", wb_ram_write_vld, 0);
        chk("idle_busy", wb_busy, 0);
        chk("err_final", wb_err, err_exp);
        @(negedge clk);
        chk("done_single", wb_done, 0);
    endtask

    initial begin
        rst                    = 1'b1;
        lsu_wb_ctrl_start      = 1'b0;
        lsu_wb_ctrl_row_len    = '0;
        lsu_wb_ctrl_col_len    = '0;
        lsu_wb_ctrl_start_addr = '0;
        mxu_wb_vld             = '0;
        mxu_wb_data            = '0;
        wb_ram_write_rdy       = 1'b0;
        clear_model();

        repeat (2) @(negedge clk);
        chk("rst_vld", wb_ram_write_vld, 0);
        chk("rst_addr", wb_ram_write_addr, 0);
        chk("rst_data", wb_ram_write_data, 0);
        chk("rst_strb", wb_ram_write_strb, 0);
        chk("rst_busy", wb_busy, 0);
        chk("rst_done", wb_done, 0);
        chk("rst_err", wb_err, 0);
        rst = 1'b0;

        run_tile(15, 15, 12'h000, 0, -1, -1, 0, 1);   // full tile
        run_tile(1, 2, 12'h0A5, 0, -1, -1, 0, 0);     // offset + partial
        run_tile(2, 3, 12'h12E, 1, -1, -1, 0, 0);     // overflow past byte 15
        run_tile(1, 4, 12'hFF0, 3, -1, -1, 0, 0);     // backpressure + wrap
        run_tile(0, 0, 12'h007, 0, -1, -1, 0, 0);     // degenerate tile
        run_tile(4, 5, 12'h230, 1, 4, 2, 0, 0);       // valid mismatch + stray start
        run_tile(3, 3, 12'h301, 0, -1, -1, 0, 0);     // start clears err
        run_tile(3, 7, 12'h340, 1, -1, -1, 1, 0);     // reset mid-WRITE
        run_tile(2, 2, 12'h350, 0, -1, -1, 0, 0);     // clean run after reset
        repeat (12) begin
            run_tile(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     12'($urandom), -1, -1, -1, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
